// File: rtl/unpacked_array_serializer.sv
// Captures a full M-lane unpacked array in one handshake and streams the lanes
// out one per cycle, lane 0 first, while counting completed frames.
module unpacked_array_serializer #(
    parameter  int M  = 2,
    parameter  int W  = 8,
    localparam int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  in_data [0:M-1],
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_index,
    output logic          out_last,
    output logic [15:0]   frame_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    state_t        r_state;
    logic [W-1:0]  r_buf [0:M-1];
    logic [IW-1:0] r_idx;
    logic [15:0]   r_frame_count;

    logic w_at_last;
    logic w_accept;

    assign w_at_last = (r_idx == LAST_IDX);

    // Combinational ready from out_ready lets the next frame load on the
    // final-lane transfer so consecutive frames have no bubble.
    assign in_ready = !reset && ((r_state == IDLE) || (out_ready && w_at_last));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_frame_count <= '0;
            for (int i = 0; i < M; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < M; i++) begin
                            r_buf[i] <= in_data[i];
                        end
                        r_idx   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (!w_at_last) begin
                            r_idx <= r_idx + IW'(1);
                        end else begin
                            r_frame_count <= r_frame_count + 16'd1;
                            r_idx         <= '0;
                            if (w_accept) begin
                                for (int i = 0; i < M; i++) begin
                                    r_buf[i] <= in_data[i];
                                end
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data    = r_buf[r_idx];
    assign out_index   = r_idx;
    assign out_valid   = (r_state == SEND);
    assign out_last    = (r_state == SEND) && w_at_last;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Bench for unpacked_array_serializer: a 2-lane/8-bit instance and a
// 1-lane/4-bit instance, each checked against a queue-based lane model.
module tb_unpacked_array_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetA, validA, readyA, inReadyA, outValidA, outLastA;
    logic [7:0]  dataA [0:1];
    logic [7:0]  outDataA;
    logic [0:0]  outIndexA;
    logic [15:0] frameCountA;

    logic        resetB, validB, readyB, inReadyB, outValidB, outLastB;
    logic [3:0]  dataB [0:0];
    logic [3:0]  outDataB;
    logic [0:0]  outIndexB;
    logic [15:0] frameCountB;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model: queue of lanes still to be emitted plus a completed-frame count.
    logic [7:0] qA [$];
    logic [3:0] qB [$];
    int         fcA = 0;
    int         fcB = 0;

    unpacked_array_serializer #(.M(2), .W(8)) dutA (
        .clock(clock), .reset(resetA), .in_data(dataA), .in_valid(validA),
        .in_ready(inReadyA), .out_data(outDataA), .out_valid(outValidA),
        .out_ready(readyA), .out_index(outIndexA), .out_last(outLastA),
        .frame_count(frameCountA)
    );

    unpacked_array_serializer #(.M(1), .W(4)) dutB (
        .clock(clock), .reset(resetB), .in_data(dataB), .in_valid(validB),
        .in_ready(inReadyB), .out_data(outDataB), .out_valid(outValidB),
        .out_ready(readyB), .out_index(outIndexB), .out_last(outLastB),
        .frame_count(frameCountB)
    );

    function automatic logic modelReadyA();
        return !resetA && (qA.size() == 0 || (readyA && qA.size() == 1));
    endfunction

    function automatic logic modelReadyB();
        return !resetB && (qB.size() == 0 || (readyB && qB.size() == 1));
    endfunction

    // Inputs change on the falling edge; outputs are observed 1 ns later.
    task automatic driveA(input logic iv, input logic [7:0] d0, input logic [7:0] d1, input logic ordy);
        @(negedge clock);
        validA   = iv;
        dataA[0] = d0;
        dataA[1] = d1;
        readyA   = ordy;
        #1;
    endtask

    task automatic advanceA();
        logic rdy;
        @(posedge clock);
        rdy = modelReadyA();
        if (qA.size() > 0 && readyA) begin
            void'(qA.pop_front());
            if (qA.size() == 0) fcA++;
        end
        if (validA && rdy) begin
            qA.push_back(dataA[0]);
            qA.push_back(dataA[1]);
        end
    endtask

    task automatic driveB(input logic iv, input logic [3:0] d0, input logic ordy);
        @(negedge clock);
        validB   = iv;
        dataB[0] = d0;
        readyB   = ordy;
        #1;
    endtask

    task automatic advanceB();
        logic rdy;
        @(posedge clock);
        rdy = modelReadyB();
        if (qB.size() > 0 && readyB) begin
            void'(qB.pop_front());
            if (qB.size() == 0) fcB++;
        end
        if (validB && rdy) qB.push_back(dataB[0]);
    endtask

    task automatic test_reset();
        resetA = 1'b1; resetB = 1'b1;
        validA = 1'b0; readyA = 1'b0; dataA[0] = 8'h00; dataA[1] = 8'h00;
        validB = 1'b0; readyB = 1'b0; dataB[0] = 4'h0;
        repeat (2) @(negedge clock);
        #1;
        testsRun++;
        if (outValidA !== 1'b0 || outDataA !== 8'h00 || outIndexA !== 1'b0 || outLastA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h idx=%b last=%b, want 0/00/0/0",
                     outValidA, outDataA, outIndexA, outLastA);
        end
        testsRun++;
        if (frameCountA !== 16'h0000 || inReadyA !== 1'b0 || inReadyB !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_count_ready: got fc=%h inReadyA=%b inReadyB=%b, want 0000/0/0",
                     frameCountA, inReadyA, inReadyB);
        end
        @(negedge clock);
        resetA = 1'b0; resetB = 1'b0;
        #1;
        testsRun++;
        if (inReadyA !== 1'b1 || inReadyB !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_ready: got A=%b B=%b, want 1/1", inReadyA, inReadyB);
        end
    endtask

    // Shared stimulus-table runner body is written out per test so each test
    // owns its comparisons.
    task automatic test_basic();
        logic       ivT   [0:3] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       rdyT  [0:3] = '{1'b1, 1'b1, 1'b1, 1'b1};
        int         fcStart = fcA;
        for (int s = 0; s < 4; s++) begin
            driveA(ivT[s], 8'hA5, 8'h3C, rdyT[s]);
            testsRun++;
            if (outValidA !== (qA.size() > 0) || inReadyA !== modelReadyA()) begin
                testsFailed++;
                $display("[TB] FAIL basic_handshake step %0d: got valid=%b ready=%b, want %b/%b",
                         s, outValidA, inReadyA, qA.size() > 0, modelReadyA());
            end
            if (qA.size() > 0) begin
                testsRun++;
                if (outDataA !== qA[0] || outIndexA !== 1'(2 - qA.size()) || outLastA !== (qA.size() == 1)) begin
                    testsFailed++;
                    $display("[TB] FAIL basic_lane step %0d: got data=%h idx=%b last=%b, want %h/%b/%b",
                             s, outDataA, outIndexA, outLastA, qA[0], 1'(2 - qA.size()), qA.size() == 1);
                end
            end
            advanceA();
        end
        testsRun++;
        if (frameCountA !== 16'(fcStart + 1) || outValidA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_done: got fc=%0d valid=%b, want %0d/0", frameCountA, outValidA, fcStart + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0T [0:5] = '{8'd11, 8'd33, 8'd33, 8'd0, 8'd0, 8'd0};
        logic [7:0] d1T [0:5] = '{8'd22, 8'd44, 8'd44, 8'd0, 8'd0, 8'd0};
        logic       ivT [0:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] seen [$];
        int         fcStart = fcA;
        for (int s = 0; s < 6; s++) begin
            driveA(ivT[s], d0T[s], d1T[s], 1'b1);
            testsRun++;
            if (outValidA !== (qA.size() > 0) || inReadyA !== modelReadyA() ||
                (qA.size() > 0 && outDataA !== qA[0])) begin
                testsFailed++;
                $display("[TB] FAIL b2b step %0d: got valid=%b ready=%b data=%h, want %b/%b/%h",
                         s, outValidA, inReadyA, outDataA, qA.size() > 0, modelReadyA(),
                         (qA.size() > 0) ? qA[0] : 8'h00);
            end
            if (outValidA === 1'b1) seen.push_back(outDataA);
            advanceA();
        end
        testsRun++;
        if (seen.size() != 4 || seen[0] !== 8'd11 || seen[1] !== 8'd22 || seen[2] !== 8'd33 || seen[3] !== 8'd44) begin
            testsFailed++;
            $display("[TB] FAIL b2b_sequence: got %0d lanes, want 11,22,33,44 with no gap", seen.size());
        end
        testsRun++;
        if (frameCountA !== 16'(fcStart + 2)) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count: got %0d, want %0d", frameCountA, fcStart + 2);
        end
    endtask

    task automatic test_backpressure();
        logic       ivT  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       rdyT [0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] d0T  [0:6] = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] d1T  [0:6] = '{8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int s = 0; s < 7; s++) begin
            driveA(ivT[s], d0T[s], d1T[s], rdyT[s]);
            testsRun++;
            if (outValidA !== (qA.size() > 0) || inReadyA !== modelReadyA() ||
                (qA.size() > 0 && (outDataA !== qA[0] || outIndexA !== 1'(2 - qA.size())))) begin
                testsFailed++;
                $display("[TB] FAIL backpressure step %0d: got valid=%b ready=%b data=%h idx=%b",
                         s, outValidA, inReadyA, outDataA, outIndexA);
            end
            if (s >= 1 && s <= 3) begin
                testsRun++;
                if (outDataA !== 8'h01 || outIndexA !== 1'b0 || inReadyA !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL backpressure_hold step %0d: got data=%h idx=%b ready=%b, want 01/0/0",
                             s, outDataA, outIndexA, inReadyA);
                end
            end
            advanceA();
        end
    endtask

    task automatic test_async_reset();
        driveA(1'b1, 8'h55, 8'h66, 1'b1);
        advanceA();
        driveA(1'b0, 8'h00, 8'h00, 1'b1);
        advanceA();
        @(negedge clock);
        #2;
        resetA = 1'b1;
        #1;
        testsRun++;
        if (outValidA !== 1'b0 || outDataA !== 8'h00 || outIndexA !== 1'b0 ||
            frameCountA !== 16'h0000 || inReadyA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got valid=%b data=%h idx=%b fc=%h ready=%b, want all 0",
                     outValidA, outDataA, outIndexA, frameCountA, inReadyA);
        end
        qA.delete();
        fcA = 0;
        @(posedge clock);
        @(negedge clock);
        resetA = 1'b0;
        driveA(1'b1, 8'h77, 8'h88, 1'b1);
        advanceA();
        for (int s = 0; s < 2; s++) begin
            driveA(1'b0, 8'h00, 8'h00, 1'b1);
            testsRun++;
            if (outValidA !== 1'b1 || outDataA !== ((s == 0) ? 8'h77 : 8'h88) || outIndexA !== 1'(s)) begin
                testsFailed++;
                $display("[TB] FAIL after_reset lane %0d: got valid=%b data=%h idx=%b",
                         s, outValidA, outDataA, outIndexA);
            end
            advanceA();
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            driveA(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            testsRun++;
            if (outValidA !== (qA.size() > 0) || inReadyA !== modelReadyA() ||
                frameCountA !== 16'(fcA)) begin
                testsFailed++;
                $display("[TB] FAIL random_ctrl cycle %0d: got valid=%b ready=%b fc=%0d, want %b/%b/%0d",
                         s, outValidA, inReadyA, frameCountA, qA.size() > 0, modelReadyA(), fcA);
            end
            if (qA.size() > 0) begin
                testsRun++;
                if (outDataA !== qA[0] || outIndexA !== 1'(2 - qA.size()) || outLastA !== (qA.size() == 1)) begin
                    testsFailed++;
                    $display("[TB] FAIL random_lane cycle %0d: got data=%h idx=%b last=%b, want %h/%b/%b",
                             s, outDataA, outIndexA, outLastA, qA[0], 1'(2 - qA.size()), qA.size() == 1);
                end
            end
            advanceA();
        end
    endtask

    task automatic test_m1_wrap();
        driveB(1'b1, 4'h9, 1'b1);
        testsRun++;
        if (inReadyB !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL m1_first_ready: got %b, want 1", inReadyB);
        end
        advanceB();
        for (int s = 0; s < 60; s++) begin
            driveB(1'b1, 4'($urandom), (s < 20) ? 1'b1 : 1'($urandom_range(0, 1)));
            testsRun++;
            if (outValidB !== (qB.size() > 0) || inReadyB !== modelReadyB() ||
                (qB.size() > 0 && (outDataB !== qB[0] || outLastB !== 1'b1 || outIndexB !== 1'b0))) begin
                testsFailed++;
                $display("[TB] FAIL m1_lane cycle %0d: got valid=%b ready=%b data=%h last=%b idx=%b",
                         s, outValidB, inReadyB, outDataB, outLastB, outIndexB);
            end
            if (s == 0) begin
                testsRun++;
                if (outDataB !== 4'h9) begin
                    testsFailed++;
                    $display("[TB] FAIL m1_first_data: got %h, want 9", outDataB);
                end
            end
            advanceB();
        end
        while (fcB < 65536) begin
            driveB(1'b1, 4'($urandom), 1'b1);
            if (fcB == 65535) begin
                testsRun++;
                if (frameCountB !== 16'hFFFF) begin
                    testsFailed++;
                    $display("[TB] FAIL wrap_ffff: got %h, want ffff", frameCountB);
                end
            end
            advanceB();
        end
        driveB(1'b0, 4'h0, 1'b1);
        testsRun++;
        if (frameCountB !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL wrap_zero: got %h, want 0000", frameCountB);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_random();
        test_m1_wrap();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
